// File: rtl/tri_bus_pkg.sv
// -----------------------------------------------------------------------------
// tri_bus_pkg
//   Shared types and helpers for the tri-state bus arbiter slice.
//   - state_t    : arbiter FSM encoding (IDLE / GRANT / TURN)
//   - TURN_CNT_W : width of the turnaround counter
//   - clog2()    : ceiling log2, usable in parameter expressions
// -----------------------------------------------------------------------------
package tri_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    localparam int unsigned TURN_CNT_W = 4;

    // Ceiling log2; clog2(0) = clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        longint unsigned v;
        r = 0;
        v = 1;
        while (v < longint'(value)) begin
            v = v << 1;
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches req upward from last+1 with
//   wrap-around and returns the first set index.
//   Ports:
//     req    [N-1:0]  request vector
//     last   [IW-1:0] index of the previous winner (search starts after it)
//     winner [IW-1:0] selected index (0 when valid is low)
//     valid           at least one request is set
// -----------------------------------------------------------------------------
module rr_pick
    import tri_bus_pkg::*;
#(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          valid
);

    logic [2*N-1:0] req2;
    logic [N-1:0]   rot;
    int unsigned    start;
    logic           found;

    assign req2 = {req, req};

    // Rotate so bit 0 is the master after last, priority-encode, then map the
    // rotated position back with a modulo add (N need not be a power of two).
    always_comb begin
        start  = (32'(last) + 32'd1) % N;
        rot    = N'(req2 >> start);
        valid  = |req;
        winner = '0;
        found  = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found  = 1'b1;
                winner = IW'((start + k) % N);
            end
        end
    end

endmodule

// File: rtl/tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tri_bus_arbiter
//   Round-robin owner sequencer for a shared tri-state bus. Exactly one master
//   cluster drives at a time, and every change of owner passes through an
//   all-drivers-off turnaround of TURN_CYCLES cycles followed by one IDLE
//   arbitration cycle.
//   Ports:
//     wb_clk_i   bus clock, rising edge
//     wb_rst_ni  asynchronous active-low reset
//     req_i      per-master level requests
//     gnt_o      registered one-hot grant
//     drv_en_o   per-master buffer enables, gnt_o[i] replicated DATA_WIDTH times
//     owner_o    current owner index (meaningful while busy_o)
//     busy_o     high while a grant is active
//     timeout_o  one-cycle pulse when MAX_HOLD revokes a grant
// -----------------------------------------------------------------------------
module tri_bus_arbiter
    import tri_bus_pkg::*;
#(
    parameter  int unsigned NUM_MASTERS = 4,
    parameter  int unsigned DATA_WIDTH  = 32,
    parameter  int unsigned TURN_CYCLES = 1,
    parameter  int unsigned MAX_HOLD    = 0,
    localparam int unsigned OW          = clog2(NUM_MASTERS)
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_ni,
    input  logic [NUM_MASTERS-1:0]            req_i,
    output logic [NUM_MASTERS-1:0]            gnt_o,
    output logic [NUM_MASTERS*DATA_WIDTH-1:0] drv_en_o,
    output logic [OW-1:0]                     owner_o,
    output logic                              busy_o,
    output logic                              timeout_o
);

    localparam int unsigned HOLD_W = (clog2(MAX_HOLD + 1) > 0) ? clog2(MAX_HOLD + 1) : 1;
    localparam logic [HOLD_W-1:0]     HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
    localparam logic [TURN_CNT_W-1:0] TURN_LAST = TURN_CNT_W'(TURN_CYCLES - 1);
    localparam logic [OW-1:0]         LAST_RST  = OW'(NUM_MASTERS - 1);

    state_t                state;
    logic [OW-1:0]         last;
    logic [HOLD_W-1:0]     hold_cnt;
    logic [TURN_CNT_W-1:0] turn_cnt;
    logic [OW-1:0]         pick;
    logic                  pick_valid;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (OW)
    ) u_pick (
        .req    (req_i),
        .last   (last),
        .winner (pick),
        .valid  (pick_valid)
    );

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state     <= IDLE;
            last      <= LAST_RST;
            hold_cnt  <= '0;
            turn_cnt  <= '0;
            gnt_o     <= '0;
            owner_o   <= '0;
            busy_o    <= 1'b0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_o    <= NUM_MASTERS'(1) << pick;
                        owner_o  <= pick;
                        last     <= pick;
                        busy_o   <= 1'b1;
                        hold_cnt <= '0;
                        state    <= GRANT;
                    end
                end
                GRANT: begin
                    // A release takes precedence over the hold limit, so a
                    // master dropping req on its last permitted cycle sees no
                    // timeout pulse.
                    if (!req_i[owner_o]) begin
                        gnt_o    <= '0;
                        busy_o   <= 1'b0;
                        turn_cnt <= '0;
                        state    <= TURN;
                    end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        turn_cnt  <= '0;
                        timeout_o <= 1'b1;
                        state     <= TURN;
                    end else if (hold_cnt != '1) begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                TURN: begin
                    if (turn_cnt == TURN_LAST) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt + 1'b1;
                    end
                end
                default: begin
                    gnt_o  <= '0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    // Enables are a pure fan-out of the grant register.
    for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_drv
        assign drv_en_o[i*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{gnt_o[i]}};
    end

endmodule

// File: tb/tb_tri_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tri_bus_arbiter
//   Two arbiter instances: A (4 masters, 32 bits, TURN_CYCLES=2, MAX_HOLD=4)
//   and B (3 masters, 8 bits, TURN_CYCLES=1, unlimited hold). Stimulus pushes
//   expected grants into per-instance queues; a negedge monitor pops one entry
//   at each new grant and checks owner, enables, gap and grant length.
// -----------------------------------------------------------------------------
module tb_tri_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [3:0]   req_a;
    logic [2:0]   req_b;

    logic [3:0]   gnt_a;
    logic [127:0] drv_a;
    logic [1:0]   own_a;
    logic         busy_a, tmo_a;

    logic [2:0]   gnt_b;
    logic [23:0]  drv_b;
    logic [1:0]   own_b;
    logic         busy_b, tmo_b;

    tri_bus_arbiter #(
        .NUM_MASTERS (4),
        .DATA_WIDTH  (32),
        .TURN_CYCLES (2),
        .MAX_HOLD    (4)
    ) u_a (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .req_i     (req_a),
        .gnt_o     (gnt_a),
        .drv_en_o  (drv_a),
        .owner_o   (own_a),
        .busy_o    (busy_a),
        .timeout_o (tmo_a)
    );

    tri_bus_arbiter #(
        .NUM_MASTERS (3),
        .DATA_WIDTH  (8),
        .TURN_CYCLES (1),
        .MAX_HOLD    (0)
    ) u_b (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .req_i     (req_b),
        .gnt_o     (gnt_b),
        .drv_en_o  (drv_b),
        .owner_o   (own_b),
        .busy_o    (busy_b),
        .timeout_o (tmo_b)
    );

    // Uniform views of both instances.
    logic [3:0]   g4   [2];
    logic [127:0] dv   [2];
    logic [1:0]   own  [2];
    logic         busy [2];
    logic         tmo  [2];

    assign g4[0]   = gnt_a;
    assign g4[1]   = {1'b0, gnt_b};
    assign dv[0]   = drv_a;
    assign dv[1]   = {104'd0, drv_b};
    assign own[0]  = own_a;
    assign own[1]  = own_b;
    assign busy[0] = busy_a;
    assign busy[1] = busy_b;
    assign tmo[0]  = tmo_a;
    assign tmo[1]  = tmo_b;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        int         gap;   // zero-grant cycles before this grant, -1 = any
        int         len;   // grant length in cycles, 0 = not checked
        bit         tmo;   // grant ends by timeout
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input int d, input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL dut%0d %s: got %0h, expected %0h (t=%0t)", d, nm, act, exp, $time);
        end
    endtask

    function automatic logic [127:0] expand(input logic [3:0] g, input int dw);
        logic [127:0] r;
        r = '0;
        for (int b = 0; b < 4 * dw; b++) r[b] = g[b / dw];
        return r;
    endfunction

    task automatic push(input int d, input logic [3:0] g, input logic [1:0] o,
                        input int gap, input int len, input bit t);
        exp_t e;
        e.gnt = g; e.owner = o; e.gap = gap; e.len = len; e.tmo = t;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    // ---------------- monitor ----------------
    logic [3:0] prev [2];
    int         zrun [2];
    int         clen [2];
    exp_t       cur  [2];

    task automatic mon(input int d);
        logic [3:0] g;
        bit         ended;
        bit         have;
        exp_t       e;
        int         dw;
        dw = (d == 0) ? 32 : 8;
        if (!rst_n) begin
            prev[d] = '0;
            zrun[d] = 0;
            clen[d] = 0;
            return;
        end
        g     = g4[d];
        ended = (prev[d] != 4'd0) && (g == 4'd0);
        check(d, "onehot0", 128'($onehot0(g)), 128'd1);
        check(d, "direct_owner_switch", 128'((prev[d] != 4'd0) && (g != 4'd0) && (g != prev[d])), 128'd0);
        check(d, "timeout_pulse", 128'(tmo[d]), 128'(ended ? cur[d].tmo : 1'b0));
        if (ended) begin
            if (cur[d].len > 0) check(d, "grant_len", 128'(clen[d]), 128'(cur[d].len));
            check(d, "busy_after_release", 128'(busy[d]), 128'd0);
            check(d, "drv_after_release", dv[d], 128'd0);
        end
        if (prev[d] == 4'd0 && g != 4'd0) begin
            have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
            if (!have) begin
                check(d, "unexpected_grant", 128'(g), 128'd0);
                cur[d].len = 0;
                cur[d].tmo = 1'b0;
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                cur[d] = e;
                check(d, "gnt", 128'(g), 128'(e.gnt));
                check(d, "owner", 128'(own[d]), 128'(e.owner));
                check(d, "busy", 128'(busy[d]), 128'd1);
                check(d, "drv_en", dv[d], expand(e.gnt, dw));
                if (e.gap >= 0) check(d, "gap", 128'(zrun[d]), 128'(e.gap));
            end
            clen[d] = 1;
        end else if (g != 4'd0) begin
            clen[d]++;
        end
        zrun[d] = (g == 4'd0) ? zrun[d] + 1 : 0;
        prev[d] = g;
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int d, input logic [3:0] v);
        if (d == 0) req_a = v;
        else        req_b = v[2:0];
    endtask

    function automatic logic [3:0] get_req(input int d);
        return (d == 0) ? req_a : {1'b0, req_b};
    endfunction

    // Waits past any current grant, then for the next one.
    task automatic wait_grant(input int d, output logic [3:0] g);
        int n;
        n = 0;
        @(negedge clk);
        while (g4[d] != 4'd0 && n < 60) begin @(negedge clk); n++; end
        while (g4[d] == 4'd0 && n < 60) begin @(negedge clk); n++; end
        check(d, "grant_wait_in_budget", 128'(n < 60), 128'd1);
        g = g4[d];
    endtask

    // Called at the negedge a grant is first seen; keeps req for n grant
    // cycles. mode 0: drop own bit, 1: drop then re-request, 2: drop all.
    task automatic hold(input int d, input logic [3:0] g, input int n, input int mode);
        repeat (n - 1) @(posedge clk);
        #1;
        if (mode == 2) set_req(d, 4'd0);
        else           set_req(d, get_req(d) & ~g);
        if (mode == 1) begin
            @(posedge clk);
            #1;
            set_req(d, get_req(d) | g);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [3:0] g;
        rst_n = 1'b1;
        req_a = '0;
        req_b = '0;
        #1 rst_n = 1'b0;
        #3;
        check(0, "rst_gnt", 128'(gnt_a), 128'd0);
        check(0, "rst_drv", drv_a, 128'd0);
        check(0, "rst_owner", 128'(own_a), 128'd0);
        check(0, "rst_busy", 128'(busy_a), 128'd0);
        check(0, "rst_timeout", 128'(tmo_a), 128'd0);
        check(1, "rst_gnt", 128'(gnt_b), 128'd0);
        check(1, "rst_drv", 128'(drv_b), 128'd0);
        check(1, "rst_busy", 128'(busy_b), 128'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Two requesters, master 0 first; master 2 follows after turnaround.
        repeat (2) @(posedge clk);
        #1;
        push(0, 4'b0001, 2'd0, -1, 3, 1'b0);
        push(0, 4'b0100, 2'd2, 3, 2, 1'b0);
        req_a = 4'b0101;
        @(negedge clk);
        check(0, "no_comb_path", 128'(gnt_a), 128'd0);
        @(negedge clk);
        check(0, "latency_gnt", 128'(gnt_a), 128'b0001);
        hold(0, 4'b0001, 3, 0);
        wait_grant(0, g);
        hold(0, g, 2, 0);

        // Reset in the middle of a grant drops enables immediately.
        repeat (4) @(posedge clk);
        #1;
        push(0, 4'b0010, 2'd1, -1, 0, 1'b0);
        req_a = 4'b0010;
        wait_grant(0, g);
        @(posedge clk);
        #2;
        check(0, "pre_reset_gnt", 128'(gnt_a), 128'b0010);
        #1 rst_n = 1'b0;
        #1;
        check(0, "async_rst_gnt", 128'(gnt_a), 128'd0);
        check(0, "async_rst_drv", drv_a, 128'd0);
        check(0, "async_rst_busy", 128'(busy_a), 128'd0);
        check(0, "async_rst_owner", 128'(own_a), 128'd0);
        req_a = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;

        // All four request; rotation 0,1,2,3,0 proves priority restarts at 0.
        repeat (2) @(posedge clk);
        #1;
        push(0, 4'b0001, 2'd0, -1, 3, 1'b0);
        push(0, 4'b0010, 2'd1, 3, 3, 1'b0);
        push(0, 4'b0100, 2'd2, 3, 3, 1'b0);
        push(0, 4'b1000, 2'd3, 3, 3, 1'b0);
        push(0, 4'b0001, 2'd0, 3, 3, 1'b0);
        req_a = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_grant(0, g);
            hold(0, g, 3, (i < 4) ? 1 : 2);
        end

        // MAX_HOLD: master 2 revoked after 4 cycles, master 1 served, then
        // master 2 again (revoked) and re-wins alone after turnaround.
        repeat (3) @(posedge clk);
        #1;
        push(0, 4'b0100, 2'd2, -1, 4, 1'b1);
        push(0, 4'b0010, 2'd1, 3, 3, 1'b0);
        push(0, 4'b0100, 2'd2, 3, 4, 1'b1);
        push(0, 4'b0100, 2'd2, 3, 2, 1'b0);
        req_a = 4'b0100;
        wait_grant(0, g);
        @(posedge clk);
        #1 req_a = req_a | 4'b0010;
        wait_grant(0, g);
        hold(0, g, 3, 0);
        wait_grant(0, g);
        wait_grant(0, g);
        hold(0, g, 2, 0);

        // Instance B: lone master 2 toggled, unlimited hold, then wrap of a
        // non-power-of-two pointer.
        repeat (2) @(posedge clk);
        #1;
        push(1, 4'b0100, 2'd2, -1, 1, 1'b0);
        set_req(1, 4'b0100);
        wait_grant(1, g);
        hold(1, g, 1, 0);
        repeat (3) @(posedge clk);
        #1;
        push(1, 4'b0100, 2'd2, -1, 2, 1'b0);
        set_req(1, 4'b0100);
        wait_grant(1, g);
        hold(1, g, 2, 0);
        repeat (3) @(posedge clk);
        #1;
        push(1, 4'b0100, 2'd2, -1, 20, 1'b0);
        set_req(1, 4'b0100);
        wait_grant(1, g);
        hold(1, g, 20, 0);
        repeat (3) @(posedge clk);
        #1;
        push(1, 4'b0001, 2'd0, -1, 2, 1'b0);
        push(1, 4'b0010, 2'd1, 2, 2, 1'b0);
        push(1, 4'b0100, 2'd2, 2, 2, 1'b0);
        push(1, 4'b0001, 2'd0, 2, 2, 1'b0);
        set_req(1, 4'b0111);
        for (int i = 0; i < 4; i++) begin
            wait_grant(1, g);
            hold(1, g, 2, (i < 3) ? 1 : 2);
        end

        repeat (10) @(posedge clk);
        check(0, "queue_drained", 128'(q0.size()), 128'd0);
        check(1, "queue_drained", 128'(q1.size()), 128'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
